readout_scheduler: RTL and testbench
====================================

Name: readout_scheduler

Overview:
- Sequences the TRU register readout engine. It queues incoming L0 trigger events, each carrying a buffer base address.
- For each event it issues one readout request per time point and steps point_address across a programmed window.
- It paces requests against the engine's active-low transfer strobe (trsf), so only one readout is in flight at a time.
- Sits between the L0 trigger path and the readout engine; drives that engine's data_out_sign, point_address and address_L0.

Parameters:
- DEPTH, 4, L0 event queue depth (power of 2, ≥2).
- PTR_W, 2, log2(DEPTH).
- PT_W, 7, point_address width.
- TIMEOUT, 63, max clocks to wait for trsf to go low after a request.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  allows new events to start.
- l0_valid  in  1  L0 event strobe.
- l0_address  in  8  L0 buffer base address for the event.
- l0_ready  out  1  queue can accept an event (count<DEPTH).
- first_point  in  PT_W  first time point of the window.
- n_points  in  PT_W  points per event; 0 is treated as 1.
- trsf  in  1  engine transfer strobe, low while a readout is active.
- data_out_sign  out  1  readout request level to the engine.
- point_address  out  PT_W  current time point.
- address_L0  out  8  base address of the event being read.
- busy  out  1  FSM not in IDLE.
- event_done  out  1  one-clock pulse when an event finishes or aborts.
- overflow  out  1  sticky: an event was offered while the queue was full.
- timeout_err  out  1  sticky: the engine did not respond within TIMEOUT.
- queue_count  out  PTR_W+1  events currently queued.

Behaviour:
- Reset: every output and internal register goes to 0 asynchronously. l0_ready is 1 after reset. Reset mid-transfer drops data_out_sign immediately and empties the queue.
- Queue: push when l0_valid & l0_ready. A push and a pop in the same cycle leave the count unchanged. When full, l0_ready=0; a push attempt is dropped and sets overflow, even if a pop happens that cycle. Pointers wrap mod DEPTH.
- Sticky flags (overflow, timeout_err) clear only on reset.
- IDLE:
  - If enable and queue not empty → LOAD.
  - LOAD pops the head into address_L0, sets pt=first_point and rem=max(n_points,1).
  - first_point and n_points are sampled only at LOAD.
- LOAD → REQ unconditionally. data_out_sign is registered and is 1 while in REQ and WAIT_BUSY.
- REQ → WAIT_BUSY. The timeout counter clears.
- WAIT_BUSY:
  - trsf sampled 0 → WAIT_DONE; data_out_sign falls on the same edge.
  - After TIMEOUT clocks with no trsf low → set timeout_err, drop data_out_sign, abort the remaining points, pulse event_done, go to IDLE.
- WAIT_DONE: trsf sampled 1 → GAP. No timeout applies in this state.
- GAP:
  - Decrement rem.
  - If rem reaches 0 → pulse event_done and go to IDLE.
  - Otherwise pt=pt+1 (wraps mod 2^PT_W) and go to REQ.
  - GAP guarantees data_out_sign is low for ≥2 clocks between requests, which the engine's edge detect requires.
- Outputs: point_address=pt and address_L0 stay stable from LOAD until the next LOAD.
- Latency: with the FSM idle and enable=1, data_out_sign rises on the 2nd rising edge after the accepting edge.
- enable deasserted mid-event: the current event completes; no new event starts until enable returns.
- trsf already low on entering WAIT_BUSY: counts as a response, so data_out_sign is high for 2 clocks.

Decomposition:
- Shared package (tru_pkg):
  - FSM state encoding (IDLE, LOAD, REQ, WAIT_BUSY, WAIT_DONE, GAP; 3-bit).
  - Default DEPTH, PT_W and TIMEOUT.
- One sub-module: l0_event_fifo, holding the 8-bit queue, count, overflow detection and l0_ready.

Test Plan:
- Single event: enable=1, n_points=3, first_point=5, l0_address=0x20. The engine model holds trsf low for 30 clocks, 2 clocks after each request rise.
  - Expect 3 requests with point_address 5,6,7 and address_L0=0x20.
  - Expect one event_done pulse, then busy=0.
- Queue full: engine stalled, push 5 events back-to-back.
  - l0_ready=0 after the 4th; the 5th is dropped; overflow=1; queue_count=4.
  - Once the engine runs, events are served in order of arrival.
- Timeout: trsf held at 1.
  - data_out_sign high for 63 clocks, then low.
  - timeout_err=1, event_done pulses, remaining points skipped, next event starts.
- Wrap and zero count:
  - first_point=127, n_points=2 → point_address 127 then 0.
  - n_points=0 → exactly one request.
- Reset mid-transfer: assert reset during WAIT_DONE with 2 events queued.
  - data_out_sign=0 immediately, queue_count=0, l0_ready=1, no event_done.
- enable gating: deassert enable during point 2 of 4.
  - All 4 points complete; the queued event waits until enable=1 again.

Source files
------------

// File: rtl/tru_pkg.sv
// Shared definitions for the TRU readout scheduler: FSM encoding and default sizing.
package tru_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    REQ       = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } state_t;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_PT_W    = 7;
  localparam int DEF_TIMEOUT = 63;

endpackage

// File: rtl/readout_scheduler_if.sv
// L0 trigger handshake and readout-engine signals seen by the scheduler.
interface readout_scheduler_if #(
  parameter int PT_W = tru_pkg::DEF_PT_W
);
  logic            l0_valid;
  logic [7:0]      l0_address;
  logic            l0_ready;
  logic            trsf;
  logic            data_out_sign;
  logic [PT_W-1:0] point_address;
  logic [7:0]      address_L0;

  // master: trigger path plus engine; slave: the scheduler itself
  modport master (
    output l0_valid, l0_address, trsf,
    input  l0_ready, data_out_sign, point_address, address_L0
  );

  modport slave (
    input  l0_valid, l0_address, trsf,
    output l0_ready, data_out_sign, point_address, address_L0
  );
endinterface

// File: rtl/readout_scheduler_fifo.sv
// L0 event queue: 8-bit base addresses, occupancy count, ready and sticky overflow.
module l0_event_fifo
  import tru_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [7:0]       din,
  output logic             ready,
  input  logic             pop,
  output logic [7:0]       head,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             do_pop;

  // ready depends only on the registered count, so a same-cycle pop never frees a slot
  assign ready  = (count < (PTR_W+1)'(DEPTH));
  assign push   = valid & ready;
  assign do_pop = pop & (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (valid && !ready) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/readout_scheduler.sv
// Readout scheduler: serves queued L0 events, issuing one request per time point
// and pacing each request against the engine's active-low transfer strobe.
//  state     | meaning
//  IDLE      | wait for enable and a queued event
//  LOAD      | pop event, latch first point and point count
//  REQ       | request raised, arm response timer
//  WAIT_BUSY | wait for trsf low, abort on timeout
//  WAIT_DONE | wait for trsf high
//  GAP       | count the point, step or finish
module readout_scheduler
  import tru_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PTR_W   = $clog2(DEPTH),
  parameter int PT_W    = DEF_PT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [PT_W-1:0]   first_point,
  input  logic [PT_W-1:0]   n_points,
  readout_scheduler_if.slave bus,
  output logic              busy,
  output logic              event_done,
  output logic              overflow,
  output logic              timeout_err,
  output logic [PTR_W:0]    queue_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  logic [PT_W-1:0]   pt;
  logic [PT_W-1:0]   rem;
  logic [TMR_W-1:0]  tmr;
  logic [7:0]        addr;
  logic [7:0]        head;
  logic              dos;
  logic              pop;
  logic              done_nxt;
  logic              to_hit;

  l0_event_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .valid    (bus.l0_valid),
    .din      (bus.l0_address),
    .ready    (bus.l0_ready),
    .pop      (pop),
    .head     (head),
    .count    (queue_count),
    .overflow (overflow)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE:      if (enable && queue_count != '0) state_nxt = LOAD;
      LOAD: begin
        pop       = 1'b1;
        state_nxt = REQ;
      end
      REQ:       state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!bus.trsf) begin
          state_nxt = WAIT_DONE;
        end else if (tmr == '0) begin
          to_hit    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (bus.trsf) state_nxt = GAP;
      GAP: begin
        if (rem == PT_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = REQ;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pt          <= '0;
      rem         <= '0;
      tmr         <= '0;
      addr        <= '0;
      dos         <= 1'b0;
      event_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      dos        <= (state_nxt == REQ) || (state_nxt == WAIT_BUSY);
      event_done <= done_nxt;
      if (to_hit) timeout_err <= 1'b1;
      case (state)
        LOAD: begin
          addr <= head;
          pt   <= first_point;
          rem  <= (n_points == '0) ? PT_W'(1) : n_points;
        end
        // REQ plus the WAIT_BUSY cycles spanning TMR values TIMEOUT-2..0 give TIMEOUT request clocks
        REQ:       tmr <= TMR_W'(TIMEOUT - 2);
        WAIT_BUSY: if (tmr != '0) tmr <= tmr - TMR_W'(1);
        GAP: begin
          rem <= rem - PT_W'(1);
          if (rem != PT_W'(1)) pt <= pt + PT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy              = (state != IDLE);
  assign bus.data_out_sign = dos;
  assign bus.point_address = pt;
  assign bus.address_L0    = addr;

endmodule

// File: tb/tb_readout_scheduler.sv
// Directed bench for readout_scheduler with a simple trsf engine model and request monitor.
module tb_readout_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] first_point = '0;
  logic [6:0] n_points = '0;
  logic       busy, event_done, overflow, timeout_err;
  logic [2:0] queue_count;
  logic       eng_on = 1'b0;

  int tests = 0;
  int fails = 0;

  readout_scheduler_if #(.PT_W(7)) bus ();

  readout_scheduler #(.DEPTH(4), .PTR_W(2), .PT_W(7), .TIMEOUT(63)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .first_point (first_point),
    .n_points    (n_points),
    .bus         (bus),
    .busy        (busy),
    .event_done  (event_done),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  // monitor: logs each request rise, its high time and event_done pulses
  logic [6:0] req_pt[$];
  logic [7:0] req_addr[$];
  int         hi_q[$];
  int         done_cnt = 0;
  int         hi_cur = 0;
  logic       mon_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.data_out_sign && !mon_prev) begin
      req_pt.push_back(bus.point_address);
      req_addr.push_back(bus.address_L0);
      hi_cur = 0;
    end
    if (bus.data_out_sign) hi_cur++;
    if (!bus.data_out_sign && mon_prev) hi_q.push_back(hi_cur);
    if (event_done) done_cnt++;
    mon_prev = bus.data_out_sign;
  end

  // engine model: trsf low for 30 clocks, starting 2 clocks after a request rise
  initial begin
    logic eng_prev;
    eng_prev = 1'b0;
    bus.trsf = 1'b1;
    forever begin
      @(negedge clk);
      if (eng_on && !reset && bus.data_out_sign && !eng_prev) begin
        repeat (2) @(negedge clk);
        bus.trsf = 1'b0;
        repeat (30) @(negedge clk);
        bus.trsf = 1'b1;
      end
      eng_prev = bus.data_out_sign;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] a);
    bus.l0_valid   = 1'b1;
    bus.l0_address = a;
    @(negedge clk);
    bus.l0_valid   = 1'b0;
  endtask

  task automatic wait_req(input int n, input int budget, input string tag);
    int k = 0;
    while (req_pt.size() < n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(req_pt.size() >= n), 1);
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cnt < n && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(done_cnt >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (!(busy == 1'b0 && queue_count == 3'd0) && k < budget) begin @(negedge clk); k++; end
    check(tag, 32'(busy == 1'b0 && queue_count == 3'd0), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int rb, db;
    bus.l0_valid   = 1'b0;
    bus.l0_address = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_dos", bus.data_out_sign, 0);
    check("rst_ready", bus.l0_ready, 1);
    check("rst_count", queue_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", event_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tout", timeout_err, 0);
    check("rst_pt", bus.point_address, 0);
    check("rst_addr", bus.address_L0, 0);
    reset = 1'b0;
    @(negedge clk);

    // single event, 3 points from 5, latency to first request
    enable = 1'b1; first_point = 7'd5; n_points = 7'd3; eng_on = 1'b1;
    push(8'h20);
    check("t1_count", queue_count, 1);
    check("t1_dos_e0", bus.data_out_sign, 0);
    @(negedge clk);
    check("t1_busy_load", busy, 1);
    check("t1_dos_e1", bus.data_out_sign, 0);
    @(negedge clk);
    check("t1_dos_e2", bus.data_out_sign, 1);
    check("t1_pt_first", bus.point_address, 5);
    check("t1_addr", bus.address_L0, 8'h20);
    check("t1_popped", queue_count, 0);
    wait_idle(600, "t1_idle");
    check("t1_nreq", req_pt.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_pt", req_pt[i], 32'(5 + i));
      check("t1_req_addr", req_addr[i], 8'h20);
    end
    check("t1_done", done_cnt, 1);
    check("t1_tout", timeout_err, 0);
    check("t1_pt_hold", bus.point_address, 7);

    // queue full with scheduler held off
    rb = req_pt.size(); db = done_cnt;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_ready", bus.l0_ready, 32'(i < 4));
      bus.l0_valid   = 1'b1;
      bus.l0_address = 8'(8'h41 + i);
      @(negedge clk);
    end
    bus.l0_valid = 1'b0;
    check("t2_ovf", overflow, 1);
    check("t2_count", queue_count, 4);
    check("t2_busy", busy, 0);
    first_point = 7'd16; n_points = 7'd1; enable = 1'b1;
    wait_idle(1000, "t2_idle");
    check("t2_nreq", req_pt.size() - rb, 4);
    for (int i = 0; i < 4; i++) check("t2_order", req_addr[rb + i], 32'(8'h41 + i));
    check("t2_done", done_cnt - db, 4);
    check("t2_ovf_sticky", overflow, 1);

    // timeout: engine silent
    rb = req_pt.size(); db = done_cnt;
    eng_on = 1'b0; first_point = 7'd0; n_points = 7'd3;
    push(8'h50);
    push(8'h51);
    wait_idle(400, "t3_idle");
    check("t3_nreq", req_pt.size() - rb, 2);
    check("t3_addr0", req_addr[rb], 8'h50);
    check("t3_addr1", req_addr[rb + 1], 8'h51);
    check("t3_hi0", hi_q[rb], 63);
    check("t3_hi1", hi_q[rb + 1], 63);
    check("t3_tout", timeout_err, 1);
    check("t3_done", done_cnt - db, 2);
    check("t3_dos", bus.data_out_sign, 0);

    // point wrap, window sampled at LOAD only, zero point count
    rb = req_pt.size(); db = done_cnt;
    eng_on = 1'b1; first_point = 7'd127; n_points = 7'd2;
    push(8'h60);
    wait_req(rb + 1, 100, "t4_first_req");
    first_point = 7'd9; n_points = 7'd0;
    push(8'h61);
    wait_idle(600, "t4_idle");
    check("t4_nreq", req_pt.size() - rb, 3);
    check("t4_pt0", req_pt[rb], 127);
    check("t4_pt1", req_pt[rb + 1], 0);
    check("t4_pt2", req_pt[rb + 2], 9);
    check("t4_addr1", req_addr[rb + 1], 8'h60);
    check("t4_addr2", req_addr[rb + 2], 8'h61);
    check("t4_done", done_cnt - db, 2);

    // reset during WAIT_DONE with two events queued
    rb = req_pt.size();
    first_point = 7'd1; n_points = 7'd1;
    push(8'h70);
    push(8'h71);
    push(8'h72);
    wait_req(rb + 1, 50, "t5_req");
    begin
      int k = 0;
      while (bus.trsf !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    end
    check("t5_trsf_low", bus.trsf, 0);
    repeat (2) @(negedge clk);
    check("t5_count_pre", queue_count, 2);
    check("t5_busy_pre", busy, 1);
    db = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("t5_dos", bus.data_out_sign, 0);
    check("t5_count", queue_count, 0);
    check("t5_ready", bus.l0_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_tout_clr", timeout_err, 0);
    repeat (40) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_done", done_cnt - db, 0);
    check("t5_no_req", req_pt.size() - rb, 1);
    check("t5_idle", busy, 0);

    // enable dropped mid-event
    rb = req_pt.size(); db = done_cnt;
    enable = 1'b1; first_point = 7'd20; n_points = 7'd4;
    push(8'h80);
    wait_req(rb + 2, 200, "t6_second_req");
    enable = 1'b0;
    push(8'h81);
    wait_done(db + 1, 400, "t6_done_wait");
    @(negedge clk);
    check("t6_nreq", req_pt.size() - rb, 4);
    for (int i = 0; i < 4; i++) check("t6_pt", req_pt[rb + i], 32'(20 + i));
    repeat (20) @(negedge clk);
    check("t6_held_busy", busy, 0);
    check("t6_held_count", queue_count, 1);
    check("t6_held_nreq", req_pt.size() - rb, 4);
    n_points = 7'd1;
    enable = 1'b1;
    wait_idle(200, "t6_idle");
    check("t6_nreq_final", req_pt.size() - rb, 5);
    check("t6_last_addr", req_addr[rb + 4], 8'h81);
    check("t6_last_pt", req_pt[rb + 4], 20);
    check("t6_done", done_cnt - db, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
